// File: rtl/branch_resolve_unit.sv
// Branch compare, PC-select and 2-bit saturating-counter BHT with registered mispredict redirect.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned PC_LSB    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] DataA,
  input  logic [XLEN-1:0] DataB,
  input  logic [2:0]      Branch,
  input  logic            Jump,
  input  logic            ex_pred_taken,
  output logic            BrEq,
  output logic            BrLT,
  output logic            PCSel,
  output logic            redirect,
`ifdef BRU_PERF_CNT_EN
  output logic            redirect_taken,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mis_cnt
`else
  output logic            redirect_taken
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_ctr;
  logic [1:0]       ctr_d;
  logic             cond;
  logic             is_br;
  logic             mispredict;
  logic             redirect_q;
  logic             redirect_taken_q;
  logic             unused_pc;

  assign if_idx    = if_pc[PC_LSB +: IDX_W];
  assign ex_idx    = ex_pc[PC_LSB +: IDX_W];
  assign unused_pc = ^{if_pc, ex_pc};

  // No bypass: a same-cycle read of the entry being trained sees the old counter.
  assign if_pred_taken = bht_q[if_idx][1];
  assign ex_ctr        = bht_q[ex_idx];

  assign BrEq = (DataA == DataB);
  assign BrLT = Branch[2] ? (DataA < DataB) : ($signed(DataA) < $signed(DataB));

  always_comb begin
    cond = 1'b0;
    unique case (Branch)
      3'b000:          cond = BrEq;
      3'b001:          cond = !BrEq;
      3'b010, 3'b100:  cond = BrLT;
      3'b011, 3'b101:  cond = !BrLT;
      default:         cond = 1'b0;
    endcase
  end

  assign PCSel      = ex_valid & (Jump | cond);
  assign is_br      = ex_valid & !Jump & (Branch <= 3'b101);
  assign mispredict = ex_valid & (PCSel != ex_pred_taken);

  always_comb begin
    ctr_d = ex_ctr;
    if (PCSel) begin
      if (ex_ctr != 2'b11) ctr_d = ex_ctr + 2'd1;
    end else begin
      if (ex_ctr != 2'b00) ctr_d = ex_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (is_br) begin
      bht_q[ex_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q       <= 1'b0;
      redirect_taken_q <= 1'b0;
    end else begin
      redirect_q       <= mispredict;
      redirect_taken_q <= mispredict & PCSel;
    end
  end

  assign redirect       = redirect_q;
  assign redirect_taken = redirect_taken_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      if (is_br)              perf_br_q  <= perf_br_q + 32'd1;
      if (is_br & mispredict) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_br_cnt  = perf_br_q;
  assign perf_mis_cnt = perf_mis_q;
`endif

endmodule
